// File: rtl/wb_arbiter.sv
// Write-back arbiter for the single register-file write port: ALU results have
// absolute priority, MDU/load results are buffered in a small FIFO and tracked in busy_mask.
module wb_arbiter #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     alu_valid,
    input  logic [4:0]               alu_reg,
    input  logic [31:0]              alu_data,
    input  logic                     mdu_valid,
    output logic                     mdu_ready,
    input  logic [4:0]               mdu_reg,
    input  logic [31:0]              mdu_data,
    output logic                     RegWrite,
    output logic [4:0]               WriteReg,
    output logic [31:0]              WriteData,
    output logic [31:0]              busy_mask,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [4:0]       ent_reg  [DEPTH];
    logic [31:0]      ent_data [DEPTH];
    logic [DEPTH-1:0] ent_live;
    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] tail_q;
    logic [CNT_W-1:0] count_q;

    logic alu_fire;
    logic mdu_fire;
    logic mdu_squash;
    logic fifo_empty;
    logic head_live;
    logic pop;
    logic bypass;
    logic push;

    assign mdu_ready  = rst_n && (count_q < CNT_FULL);
    assign fifo_count = count_q;

    // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        alu_fire   = alu_valid && (alu_reg != 5'd0);
        mdu_fire   = mdu_valid && mdu_ready && (mdu_reg != 5'd0);
        mdu_squash = alu_fire && (mdu_reg == alu_reg);
        fifo_empty = (count_q == '0);
        head_live  = !fifo_empty && ent_live[head_q];
        // A squashed head always leaves; a live head only leaves when the ALU is idle.
        pop        = !fifo_empty && (!ent_live[head_q] || !alu_fire);
        bypass     = mdu_fire && fifo_empty && !alu_fire;
        push       = mdu_fire && !bypass;
    end

    always_comb begin
        busy_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_live[i]) busy_mask[ent_reg[i]] = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            RegWrite  <= 1'b0;
            WriteReg  <= '0;
            WriteData <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            ent_live  <= '0;
            // NOTE: the payload array is cleared too; it is tiny and keeps post-reset state fully defined.
            for (int i = 0; i < DEPTH; i++) begin
                ent_reg[i]  <= '0;
                ent_data[i] <= '0;
            end
        end else begin
            RegWrite <= 1'b0;
            if (alu_fire) begin
                RegWrite  <= 1'b1;
                WriteReg  <= alu_reg;
                WriteData <= alu_data;
            end else if (head_live) begin
                RegWrite  <= 1'b1;
                WriteReg  <= ent_reg[head_q];
                WriteData <= ent_data[head_q];
            end else if (bypass) begin
                RegWrite  <= 1'b1;
                WriteReg  <= mdu_reg;
                WriteData <= mdu_data;
            end

            // WAW: a younger ALU write to the same register kills queued MDU results.
            for (int i = 0; i < DEPTH; i++) begin
                if (alu_fire && (ent_reg[i] == alu_reg)) ent_live[i] <= 1'b0;
            end

            if (pop) begin
                ent_live[head_q] <= 1'b0;
                head_q           <= head_q + PTR_ONE;
            end

            if (push) begin
                ent_reg[tail_q]  <= mdu_reg;
                ent_data[tail_q] <= mdu_data;
                ent_live[tail_q] <= !mdu_squash;
                tail_q           <= tail_q + PTR_ONE;
            end

            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule
